// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE / BURST)
//   FIFO_DATA_W : data width of the async FIFO write port
//   MAX_REQ     : largest supported producer count
//   onehot()    : index -> one-hot vector (MAX_REQ wide, caller truncates)
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int FIFO_DATA_W = 8;
    localparam int MAX_REQ     = 8;

    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority find-first-set, purely combinational.
//   req   : request vector, one bit per producer
//   ptr   : index with highest priority this round
//   found : at least one request is set
//   idx   : first set request searching upward from ptr, wrapping
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               found,
    output logic [PTR_W-1:0]   idx
);

    // Scan distances from far to near so the nearest candidate wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int c;
            c = int'(ptr) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (req[c]) begin
                found = 1'b1;
                idx   = PTR_W'(c);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter in front of the async FIFO write port (wclk domain).
// One producer owns the port for a burst of up to BURST_LEN words; words are
// forwarded only while the FIFO is not full, so nothing is dropped.
//
// Ports:
//   wclk, nRst  : write clock, async active-low reset
//   arb_en      : allows new grants; a running burst always completes
//   req_valid   : per-producer word available
//   req_data    : producer i word at [i*DATA_W +: DATA_W]
//   req_ready   : per-producer accept (at most one bit high)
//   fifo_full   : FIFO full flag
//   w_en        : FIFO write enable (combinational, = transfer)
//   data_in     : FIFO write data (owner's word in BURST, else 0)
//   grant       : registered one-hot owner, zero when idle
//   busy        : registered, high while in BURST
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; picks next producer from rr_ptr when arb_en
// BURST | owner holds the port; moves words while fifo_full is low
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4,
    parameter int DATA_W    = FIFO_DATA_W
) (
    input  logic                      wclk,
    input  logic                      nRst,
    input  logic                      arb_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      w_en,
    output logic [DATA_W-1:0]         data_in,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    arb_state_t       state;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] rr_ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic             in_burst;
    logic             owner_valid;
    logic             xfer;
    logic             last_beat;
    logic             rel;
    logic [PTR_W-1:0] ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (win_found),
        .idx   (win_idx)
    );

    assign in_burst    = (state == BURST);
    assign owner_valid = req_valid[owner];
    assign xfer        = in_burst && owner_valid && !fifo_full;
    assign last_beat   = xfer && (beat_cnt + CNT_W'(1) == CNT_W'(BURST_LEN));
    // A producer dropping valid ends its burst even while the FIFO is full,
    // so an idle owner can never park on the port.
    assign rel         = in_burst && (last_beat || !owner_valid);
    assign ptr_next    = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);

    assign w_en    = xfer;
    assign data_in = in_burst ? req_data[int'(owner)*DATA_W +: DATA_W] : '0;

    always_comb begin
        req_ready = '0;
        if (in_burst && !fifo_full) req_ready[owner] = 1'b1;
    end

    always_ff @(posedge wclk or negedge nRst) begin
        if (!nRst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant    <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_en && win_found) begin
                        state    <= BURST;
                        owner    <= win_idx;
                        grant    <= NUM_REQ'(onehot(int'(win_idx)));
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                BURST: begin
                    if (rel) begin
                        state    <= IDLE;
                        grant    <= '0;
                        busy     <= 1'b0;
                        beat_cnt <= '0;
                        rr_ptr   <= ptr_next;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: producers are modelled as word
// queues, the arbiter as a grant/burst reference evaluated once per cycle.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int BL = 4;
    localparam int DW = 8;

    logic              wclk = 1'b0;
    logic              nRst;
    logic              arb_en;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              w_en;
    logic [DW-1:0]     data_in;
    logic [NR-1:0]     grant;
    logic              busy;

    fifo_wr_arbiter #(.NUM_REQ(NR), .BURST_LEN(BL), .DATA_W(DW)) dut (
        .wclk      (wclk),
        .nRst      (nRst),
        .arb_en    (arb_en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .w_en      (w_en),
        .data_in   (data_in),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    int checks = 0;
    int errors = 0;

    // producer-side word queues and stimulus knobs
    logic [7:0]    pq [NR][$];
    logic [NR-1:0] p_en;
    int            valid_pct, full_pct, arb_pct;
    logic          full_fix, arb_cfg;

    // reference model
    bit            m_busy;
    int            m_owner, m_rr, m_beats;
    logic [7:0]    wr_log[$];
    int            grant_log[$];
    int            burst_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_rr = 0; m_beats = 0;
        for (int i = 0; i < NR; i++) pq[i].delete();
        wr_log.delete(); grant_log.delete(); burst_log.delete();
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            bit has;
            has = pq[i].size() > 0;
            req_valid[i] = p_en[i] && has && ($urandom_range(99) < valid_pct);
            req_data[i*DW +: DW] = has ? pq[i][0] : 8'($urandom);
        end
        fifo_full = full_fix || ($urandom_range(99) < full_pct);
        arb_en    = arb_cfg && ($urandom_range(99) < arb_pct);
    endtask

    // compare this cycle's outputs, then advance the model across the edge
    task automatic model_step();
        logic [NR-1:0] exp_g, exp_r;
        logic [DW-1:0] exp_d;
        bit xfer;
        xfer  = m_busy && req_valid[m_owner] && !fifo_full;
        exp_g = m_busy ? NR'(1) << m_owner : '0;
        exp_r = (m_busy && !fifo_full) ? NR'(1) << m_owner : '0;
        exp_d = m_busy ? req_data[m_owner*DW +: DW] : '0;
        chk("grant", 32'(grant), 32'(exp_g));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("req_ready", 32'(req_ready), 32'(exp_r));
        chk("w_en", 32'(w_en), 32'(xfer));
        chk("data_in", 32'(data_in), 32'(exp_d));
        if (!m_busy) begin
            if (arb_en && |req_valid) begin
                for (int k = 0; k < NR; k++) begin
                    int c;
                    c = (m_rr + k) % NR;
                    if (req_valid[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_busy = 1; m_beats = 0;
                grant_log.push_back(m_owner);
            end
        end else begin
            if (xfer) begin
                wr_log.push_back(pq[m_owner].pop_front());
                m_beats++;
            end
            if ((xfer && m_beats == BL) || !req_valid[m_owner]) begin
                burst_log.push_back(m_beats);
                m_busy = 0; m_beats = 0;
                m_rr = (m_owner + 1) % NR;
            end
        end
    endtask

    task automatic cycle();
        @(posedge wclk); #1;
        drive_inputs();
        @(negedge wclk);
        model_step();
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        req_valid = '0; req_data = '0; fifo_full = 1'b0; arb_en = 1'b0;
        p_en = '0; full_fix = 1'b0; arb_cfg = 1'b1;
        valid_pct = 100; full_pct = 0; arb_pct = 100;
        model_reset();
        repeat (2) @(posedge wclk);
        #1 nRst = 1'b1;
    endtask

    task automatic fill_all(input int n);
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < n; k++) pq[i].push_back(8'((i << 4) | (k & 15)));
    endtask

    initial begin
        int n;

        // 1: reset with toggling inputs, then quiet after release
        nRst = 1'b0;
        p_en = '0; full_fix = 1'b0; arb_cfg = 1'b1;
        valid_pct = 100; full_pct = 0; arb_pct = 100;
        model_reset();
        repeat (6) begin
            @(posedge wclk); #1;
            req_valid = NR'($urandom); req_data = ($urandom);
            fifo_full = 1'($urandom); arb_en = 1'($urandom);
            @(negedge wclk);
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_wen", 32'(w_en), 0);
            chk("rst_grant", 32'(grant), 0);
            chk("rst_busy", 32'(busy), 0);
        end
        do_reset();
        repeat (4) cycle();

        // 2: producer 1 alone, six words
        do_reset();
        p_en = 4'b0010;
        for (int k = 0; k < 6; k++) pq[1].push_back(8'hA0 + 8'(k));
        n = 0;
        while ((pq[1].size() > 0 || m_busy) && n < 40) begin cycle(); n++; end
        chk("t2_done", 32'(n < 40), 1);
        chk("t2_grants", grant_log.size(), 2);
        chk("t2_bursts", burst_log.size(), 2);
        if (burst_log.size() == 2) begin
            chk("t2_b0", burst_log[0], 4);
            chk("t2_b1", burst_log[1], 2);
        end
        chk("t2_words", wr_log.size(), 6);
        for (int k = 0; k < wr_log.size() && k < 6; k++)
            chk("t2_word", 32'(wr_log[k]), 32'(8'hA0 + k));

        // 3: everyone valid, fairness and burst length
        do_reset();
        p_en = '1;
        fill_all(8);
        n = 0;
        while (grant_log.size() < 5 && n < 100) begin cycle(); n++; end
        chk("t3_done", 32'(n < 100), 1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            chk("t3_order", grant_log[k], k % NR);
        for (int k = 0; k < 4 && k < burst_log.size(); k++)
            chk("t3_blen", burst_log[k], BL);
        for (int k = 0; k < 16 && k < wr_log.size(); k++)
            chk("t3_fifo", 32'(wr_log[k]), 32'(((k / 4) << 4) | (k % 4)));

        // 4: FIFO full for three cycles after producer 2's second word
        do_reset();
        p_en = 4'b0100;
        for (int k = 0; k < 4; k++) pq[2].push_back(8'h50 + 8'(k));
        n = 0;
        while (wr_log.size() < 2 && n < 20) begin cycle(); n++; end
        chk("t4_reach", 32'(n < 20), 1);
        full_fix = 1'b1;
        repeat (3) cycle();
        chk("t4_hold", wr_log.size(), 2);
        full_fix = 1'b0;
        n = 0;
        while (m_busy && n < 20) begin cycle(); n++; end
        chk("t4_words", wr_log.size(), 4);
        for (int k = 0; k < wr_log.size() && k < 4; k++)
            chk("t4_word", 32'(wr_log[k]), 32'(8'h50 + k));
        chk("t4_grants", grant_log.size(), 1);

        // 5: arb_en falls during producer 0's second beat
        do_reset();
        p_en = '1;
        fill_all(8);
        n = 0;
        while (wr_log.size() < 1 && n < 20) begin cycle(); n++; end
        chk("t5_reach", 32'(n < 20), 1);
        arb_cfg = 1'b0;
        repeat (10) cycle();
        chk("t5_words", wr_log.size(), 4);
        chk("t5_grants", grant_log.size(), 1);
        chk("t5_idle", 32'(busy), 0);
        arb_cfg = 1'b1;
        n = 0;
        while (grant_log.size() < 2 && n < 20) begin cycle(); n++; end
        if (grant_log.size() == 2) chk("t5_next", grant_log[1], 1);
        else chk("t5_next_seen", grant_log.size(), 2);

        // 6: async reset during producer 3's third beat
        do_reset();
        p_en = 4'b1000;
        for (int k = 0; k < 8; k++) pq[3].push_back(8'h30 + 8'(k));
        n = 0;
        while (wr_log.size() < 2 && n < 20) begin cycle(); n++; end
        chk("t6_reach", 32'(n < 20), 1);
        @(posedge wclk); #1;
        drive_inputs();
        #1;
        chk("t6_beat3", 32'(w_en), 1);
        nRst = 1'b0;
        #1;
        chk("t6_wen", 32'(w_en), 0);
        chk("t6_ready", 32'(req_ready), 0);
        chk("t6_grant", 32'(grant), 0);
        chk("t6_busy", 32'(busy), 0);
        do_reset();
        p_en = '1;
        fill_all(4);
        n = 0;
        while (grant_log.size() < 1 && n < 10) begin cycle(); n++; end
        if (grant_log.size() > 0) chk("t6_first", grant_log[0], 0);
        else chk("t6_first_seen", grant_log.size(), 1);

        // 7: random traffic with FIFO back-pressure and arb_en dropouts
        do_reset();
        p_en = '1;
        valid_pct = 75; full_pct = 25; arb_pct = 85;
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 30; k++) pq[i].push_back(8'($urandom));
        repeat (600) cycle();
        for (int k = 0; k < burst_log.size(); k++)
            chk("t7_blen_max", 32'(burst_log[k] <= BL), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
